// File: rtl/ram64_bank.sv
// ram64_bank: 64 x 16-bit memory with synchronous write and combinational read.
// It is built from eight RAM8 banks of eight words each.
// address[5:3] picks the bank through a DMux8Way-style load decode.
// address[2:0] then picks the word inside that bank.
// Reads go through a per-bank Mux8Way16 followed by a bank-level Mux8Way16.
// There is no read register and no write-through bypass.
module ram64_bank (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [5:0]  address,
  output logic [15:0] out
);

  logic [7:0]       w_bankLoad;
  logic [7:0][15:0] w_bankOut;

  // DMux8Way: steer load to exactly one bank, every other bank enable stays low
  always_comb begin
    w_bankLoad = 8'h00;
    w_bankLoad[address[5:3]] = load;
  end

  for (genvar b = 0; b < 8; b++) begin : g_bank
    logic [15:0] r_word [0:7];
    logic [7:0]  w_wordLoad;

    // DMux8Way inside the bank: steer the bank enable to one word register
    always_comb begin
      w_wordLoad = 8'h00;
      w_wordLoad[address[2:0]] = w_bankLoad[b];
    end

    // Word registers: reset clears all words and takes priority over any write
    always_ff @(posedge clk) begin
      for (int w = 0; w < 8; w++) begin
        if (reset) begin
          r_word[w] <= 16'h0000;
        end else if (w_wordLoad[w]) begin
          r_word[w] <= in;
        end
      end
    end

    // Mux8Way16 inside the bank: present the addressed word of this bank
    assign w_bankOut[b] = r_word[address[2:0]];
  end

  // Mux8Way16 across banks: combinational read with zero-cycle latency
  always_comb begin
    out = w_bankOut[address[5:3]];
  end

endmodule

// File: tb/tb_ram64_bank.sv
// tb_ram64_bank: directed self-checking bench for ram64_bank.
// The bench keeps its own 64-word model of the expected contents.
module tb_ram64_bank;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;
  logic [15:0] mdl [0:63];

  ram64_bank dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a single-edge reset and clear the expected contents
  task automatic pulseReset();
    reset = 1'b1;
    load  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
  endtask

  // Write one word on the next edge and record it in the model
  task automatic doWrite(input logic [5:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    mdl[a] = d;
  endtask

  // Reset clears words previously written with all ones
  task automatic test_reset();
    pulseReset();
    doWrite(6'd0,  16'hFFFF);
    doWrite(6'd9,  16'hFFFF);
    doWrite(6'd63, 16'hFFFF);
    pulseReset();
    for (int i = 0; i < 64; i++) begin
      address = 6'(i);
      #1;
      total++;
      if (out !== 16'h0000) begin
        bad++;
        $display("[TB] FAIL reset_clear addr=%0d got=%h exp=%h", i, out, 16'h0000);
      end
    end
  endtask

  // Fill every word with a distinct value, then read back with load low
  task automatic test_sweep();
    pulseReset();
    for (int i = 0; i < 64; i++) doWrite(6'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 64; i++) begin
      address = 6'(i);
      #1;
      total++;
      if (out !== 16'h1000 + 16'(i)) begin
        bad++;
        $display("[TB] FAIL sweep addr=%0d got=%h exp=%h", i, out, 16'h1000 + 16'(i));
      end
    end
  endtask

  // Bank edges 7/8 and 55/56, plus words 0/63 and bit 15, must not alias
  task automatic test_bank_boundary();
    logic [5:0]  addrs [0:5];
    logic [15:0] exps  [0:5];
    pulseReset();
    doWrite(6'd7,  16'hAAAA);
    doWrite(6'd8,  16'h5555);
    doWrite(6'd56, 16'h8001);
    doWrite(6'd0,  16'h8000);
    addrs = '{6'd7, 6'd8, 6'd55, 6'd56, 6'd0, 6'd63};
    exps  = '{16'hAAAA, 16'h5555, 16'h0000, 16'h8001, 16'h8000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      address = addrs[i];
      #1;
      total++;
      if (out !== exps[i]) begin
        bad++;
        $display("[TB] FAIL bank_boundary addr=%0d got=%h exp=%h", addrs[i], out, exps[i]);
      end
    end
  endtask

  // Old data is visible before the write edge and new data after it
  task automatic test_back_to_back();
    doWrite(6'd20, 16'h1234);
    address = 6'd20;
    in      = 16'hBEEF;
    load    = 1'b1;
    #1;
    total++;
    if (out !== 16'h1234) begin
      bad++;
      $display("[TB] FAIL rdw_before got=%h exp=%h", out, 16'h1234);
    end
    @(posedge clk);
    #1;
    mdl[20] = 16'hBEEF;
    total++;
    if (out !== 16'hBEEF) begin
      bad++;
      $display("[TB] FAIL rdw_after got=%h exp=%h", out, 16'hBEEF);
    end
    load = 1'b0;
    in   = 16'h0000;
    @(posedge clk);
    #1;
    total++;
    if (out !== 16'hBEEF) begin
      bad++;
      $display("[TB] FAIL rdw_hold got=%h exp=%h", out, 16'hBEEF);
    end
  endtask

  // Reset wins over a simultaneous write; the following write lands normally
  task automatic test_reset_priority();
    doWrite(6'd33, 16'h7FFF);
    reset   = 1'b1;
    load    = 1'b1;
    address = 6'd33;
    in      = 16'h4321;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_priority got=%h exp=%h", out, 16'h0000);
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    mdl[33] = 16'h4321;
    total++;
    if (out !== 16'h4321) begin
      bad++;
      $display("[TB] FAIL write_after_reset got=%h exp=%h", out, 16'h4321);
    end
    address = 6'd32;
    #1;
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_cleared_neighbour got=%h exp=%h", out, 16'h0000);
    end
  endtask

  // Address and data churn with load low must leave every word untouched
  task automatic test_hold();
    doWrite(6'd5, 16'h00F0);
    for (int e = 0; e < 50; e++) begin
      address = 6'($urandom_range(0, 63));
      in      = 16'($urandom);
      #2;
      address = 6'($urandom_range(0, 63));
      in      = 16'($urandom);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 64; i++) begin
      address = 6'(i);
      #1;
      total++;
      if (out !== mdl[i]) begin
        bad++;
        $display("[TB] FAIL hold addr=%0d got=%h exp=%h", i, out, mdl[i]);
      end
    end
    address = 6'd5;
    #1;
    total++;
    if (out !== 16'h00F0) begin
      bad++;
      $display("[TB] FAIL hold_word5 got=%h exp=%h", out, 16'h00F0);
    end
  endtask

  // Run every scenario in order and print the summary
  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    in      = 16'h0000;
    address = 6'd0;
    for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
    test_reset();
    test_sweep();
    test_bank_boundary();
    test_back_to_back();
    test_reset_priority();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
